dram_arb: RTL

//  Two-requester round-robin arbiter for the single data-RAM port of the ram block.

---
 rtl/dram_arb_pkg.sv | 22 ++
 rtl/dram_arb_if.sv | 30 +++
 rtl/dram_arb_rr_arb2.sv | 25 ++
 rtl/dram_arb.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared types and widths for the data-RAM arbiter
// Purpose: grant encoding, the per-port RAM request record and the bus widths
//          used by dram_arb, its requester interface and the rr_arb2 picker.
// Ports:   none (package).
package hxd_arb_pkg;

  localparam int XLEN   = 32;  // data and byte-address width
  localparam int ADDR_W = 14;  // RAM word-address width

  typedef enum logic {
    GNT_P0 = 1'b0,
    GNT_P1 = 1'b1
  } gnt_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [3:0]      be;
  } ram_req_t;

endpackage

// File: rtl/dram_arb_if.sv
// rtl/dram_arb_if.sv - one requester port of the data-RAM arbiter
// Purpose: bundles a requester's request channel and its read-response channel.
// Ports:   req_vld/req_we/req_addr/req_data/req_be  request from master
//          req_rdy                                 request accepted (to master)
//          rsp_data/rsp_vld                        read response (to master)
//          rsp_rdy                                 response consumed (from master)
interface dram_arb_if;
  import hxd_arb_pkg::*;

  logic            req_vld;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_data;
  logic [3:0]      req_be;
  logic            req_rdy;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_vld;
  logic            rsp_rdy;

  modport master (
    output req_vld, req_we, req_addr, req_data, req_be, rsp_rdy,
    input  req_rdy, rsp_data, rsp_vld
  );

  modport slave (
    input  req_vld, req_we, req_addr, req_data, req_be, rsp_rdy,
    output req_rdy, rsp_data, rsp_vld
  );

endinterface

// File: rtl/dram_arb_rr_arb2.sv
// rtl/dram_arb_rr_arb2.sv - two-way round-robin picker
// Purpose: picks at most one of two eligible requesters; on contention the
//          port that did not win last time is granted.
// Ports:   eligible[1:0]  per-port eligibility
//          last_gnt       port granted by the most recent accepted request
//          grant[1:0]     one-hot (or zero) grant
module rr_arb2
  import hxd_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  gnt_t       last_gnt,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_gnt == GNT_P1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dram_arb.sv
// rtl/dram_arb.sv - round-robin arbiter for the single data-RAM port
// Purpose: sequences word reads/writes from the hxd32 data port (p0) and the
//          debug/loader master (p1) onto one RAM port; read data returns to
//          the issuing port through a 1-entry response buffer per port.
// Ports:   clk_i, rst_i     clock, asynchronous active-high reset
//          p0, p1           requester ports (dram_arb_if.slave)
//          ram_en_o         RAM access strobe
//          ram_we_o         RAM byte write enables (0 = read)
//          ram_addr_o       RAM word address
//          ram_wr_data_o    RAM write data
//          ram_rd_data_i    RAM read data, valid one cycle after ram_en_o
module dram_arb
  import hxd_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  dram_arb_if.slave         p0,
  dram_arb_if.slave         p1,
  output logic              ram_en_o,
  output logic [3:0]        ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [XLEN-1:0]   ram_wr_data_o,
  input  logic [XLEN-1:0]   ram_rd_data_i
);

  logic [1:0]            req_vld;
  logic [1:0]            req_we;
  logic [1:0]            rsp_rdy;
  ram_req_t              req0;
  ram_req_t              req1;
  ram_req_t              req_sel;

  logic [1:0]            pend_q;
  logic [1:0]            rsp_vld_q;
  logic [1:0][XLEN-1:0]  rsp_data_q;
  logic                  infl_vld_q;
  gnt_t                  infl_own_q;
  gnt_t                  last_gnt_q;

  logic [1:0]            slot_free;
  logic [1:0]            eligible;
  logic [1:0]            grant_raw;
  logic [1:0]            grant;
  logic [1:0]            rd_acc;
  logic [1:0]            rsp_hs;
  logic [1:0]            capture;
  logic                  accept;
  logic                  unused_addr_bits;

  assign req_vld = {p1.req_vld, p0.req_vld};
  assign req_we  = {p1.req_we,  p0.req_we};
  assign rsp_rdy = {p1.rsp_rdy, p0.rsp_rdy};
  assign req0    = '{we: p0.req_we, addr: p0.req_addr, data: p0.req_data, be: p0.req_be};
  assign req1    = '{we: p1.req_we, addr: p1.req_addr, data: p1.req_data, be: p1.req_be};

  // A response slot frees up in the very cycle its response is consumed, so a
  // new read can be accepted in the handshake cycle. Writes never need a slot.
  assign rsp_hs    = rsp_vld_q & rsp_rdy;
  assign slot_free = ~pend_q | rsp_hs;
  assign eligible  = req_vld & (req_we | slot_free);

  rr_arb2 u_rr_arb2 (
    .eligible (eligible),
    .last_gnt (last_gnt_q),
    .grant    (grant_raw)
  );

  // Nothing may be accepted while reset is held.
  assign grant  = rst_i ? 2'b00 : grant_raw;
  assign accept = |grant;
  assign rd_acc = grant & ~req_we;

  assign req_sel = grant[1] ? req1 : req0;

  always_comb begin
    ram_en_o      = 1'b0;
    ram_we_o      = 4'h0;
    ram_addr_o    = '0;
    ram_wr_data_o = '0;
    if (accept) begin
      ram_en_o      = 1'b1;
      ram_we_o      = req_sel.we ? req_sel.be : 4'h0;
      ram_addr_o    = req_sel.addr[ADDR_W+1:2];
      ram_wr_data_o = req_sel.data;
    end
  end

  assign unused_addr_bits = ^{req_sel.addr[XLEN-1:ADDR_W+2], req_sel.addr[1:0]};

  // The in-flight register marks the cycle in which ram_rd_data_i belongs to
  // a read accepted one cycle earlier; that data lands in the owner's buffer.
  assign capture = infl_vld_q ? ((infl_own_q == GNT_P1) ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q     <= 2'b00;
      rsp_vld_q  <= 2'b00;
      rsp_data_q <= '0;
      infl_vld_q <= 1'b0;
      infl_own_q <= GNT_P0;
      last_gnt_q <= GNT_P1;
    end else begin
      if (accept) begin
        last_gnt_q <= grant[1] ? GNT_P1 : GNT_P0;
      end
      infl_vld_q <= |rd_acc;
      infl_own_q <= rd_acc[1] ? GNT_P1 : GNT_P0;
      for (int n = 0; n < 2; n++) begin
        if (rsp_hs[n]) begin
          rsp_vld_q[n] <= 1'b0;
        end
        if (capture[n]) begin
          rsp_vld_q[n]  <= 1'b1;
          rsp_data_q[n] <= ram_rd_data_i;
        end
        // A read accepted in the handshake cycle keeps the slot reserved.
        if (rd_acc[n]) begin
          pend_q[n] <= 1'b1;
        end else if (rsp_hs[n]) begin
          pend_q[n] <= 1'b0;
        end
      end
    end
  end

  assign p0.req_rdy  = grant[0];
  assign p1.req_rdy  = grant[1];
  assign p0.rsp_vld  = rsp_vld_q[0];
  assign p1.rsp_vld  = rsp_vld_q[1];
  assign p0.rsp_data = rsp_data_q[0];
  assign p1.rsp_data = rsp_data_q[1];

endmodule
